// File: rtl/mips.sv
// Single-cycle 32-bit MIPS subset core: fetch, decode, execute, memory and write-back in one clock.
// PROG_SEL picks the built-in ROM image (0 = main program, 1 = $0-protection/unknown-op image).
module mips #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64,
  parameter int unsigned PROG_SEL   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result
);

  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  localparam logic [5:0] OpR    = 6'h00;
  localparam logic [5:0] OpJ    = 6'h02;
  localparam logic [5:0] OpBeq  = 6'h04;
  localparam logic [5:0] OpAddi = 6'h08;
  localparam logic [5:0] OpLw   = 6'h23;
  localparam logic [5:0] OpSw   = 6'h2B;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [DMEM_WORDS];

  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (PROG_SEL == 0) begin
      case (idx)
        30'd0:   w = 32'h2001_0005;
        30'd1:   w = 32'h2002_0003;
        30'd2:   w = 32'h0022_1820;
        30'd3:   w = 32'h0022_2022;
        30'd4:   w = 32'hAC03_0000;
        30'd5:   w = 32'h8C05_0000;
        30'd6:   w = 32'h10A3_0001;
        30'd7:   w = 32'h2006_0001;
        30'd8:   w = 32'h0800_0008;
        default: w = 32'h0000_0000;
      endcase
    end else begin
      case (idx)
        30'd0:   w = 32'h2000_0007;
        30'd1:   w = 32'hFC00_0000;
        default: w = 32'h0000_0000;
      endcase
    end
    return w;
  endfunction

  logic [29:0] imem_idx;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, waddr;
  logic [31:0] sext_imm, rd_a, rd_b, alu_b, wdata, dmem_rdata;
  logic [31:0] pc_plus4;
  logic [DAW-1:0] dmem_idx;
  logic        reg_we, mem_we, mem_to_reg, alu_src_imm, is_beq, is_j;
  alu_op_e     alu_op;

  assign imem_idx = pc_q[31:2] % 30'(IMEM_WORDS);
  assign instr    = rom_word(imem_idx);
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign sext_imm = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    is_beq      = 1'b0;
    is_j        = 1'b0;
    waddr       = rt;
    alu_op      = AluAdd;
    case (opcode)
      OpR: begin
        waddr  = rd;
        reg_we = 1'b1;
        case (funct)
          6'h20:   alu_op = AluAdd;
          6'h22:   alu_op = AluSub;
          6'h24:   alu_op = AluAnd;
          6'h25:   alu_op = AluOr;
          6'h2A:   alu_op = AluSlt;
          default: reg_we = 1'b0;
        endcase
      end
      OpAddi: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
      end
      OpLw: begin
        reg_we      = 1'b1;
        alu_src_imm = 1'b1;
        mem_to_reg  = 1'b1;
      end
      OpSw: begin
        mem_we      = 1'b1;
        alu_src_imm = 1'b1;
      end
      OpBeq: begin
        alu_op = AluSub;
        is_beq = 1'b1;
      end
      OpJ:     is_j = 1'b1;
      default: ;
    endcase
  end

  // $0 is never written, so its storage stays at its reset value of zero.
  assign rd_a  = regs_q[rs];
  assign rd_b  = regs_q[rt];
  assign alu_b = alu_src_imm ? sext_imm : rd_b;

  always_comb begin
    alu_result = 32'h0;
    case (alu_op)
      AluAdd:  alu_result = rd_a + alu_b;
      AluSub:  alu_result = rd_a - alu_b;
      AluAnd:  alu_result = rd_a & alu_b;
      AluOr:   alu_result = rd_a | alu_b;
      AluSlt:  alu_result = {31'b0, $signed(rd_a) < $signed(alu_b)};
      default: alu_result = 32'h0;
    endcase
  end

  assign dmem_idx   = DAW'(alu_result[31:2] % 30'(DMEM_WORDS));
  assign dmem_rdata = dmem_q[dmem_idx];
  assign wdata      = mem_to_reg ? dmem_rdata : alu_result;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (is_beq && (alu_result == 32'h0)) begin
      pc_d = pc_plus4 + {sext_imm[29:0], 2'b00};
    end else if (is_j) begin
      pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 32'h0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
      for (int i = 0; i < int'(DMEM_WORDS); i++) dmem_q[i] <= 32'h0;
    end else begin
      pc_q <= pc_d;
      if (reg_we && (waddr != 5'd0)) regs_q[waddr] <= wdata;
      if (mem_we) dmem_q[dmem_idx] <= rd_b;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_mips.sv
// Directed bench for the single-cycle MIPS core: walks the built-in program and a $0/unknown-op image.
module tb_mips;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_out, alu_result;
  logic [31:0] pc_out2, alu_result2;

  int n_pass  = 0;
  int n_total = 0;

  mips #(.IMEM_WORDS(64), .DMEM_WORDS(64), .PROG_SEL(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_out     (pc_out),
    .alu_result (alu_result)
  );

  mips #(.IMEM_WORDS(64), .DMEM_WORDS(64), .PROG_SEL(1)) dut_alt (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_out     (pc_out2),
    .alu_result (alu_result2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    // Run partway into the program, then drop reset between edges.
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (pc_out !== 32'h0) $display("FAIL reset_pc_async: got %h want %h", pc_out, 32'h0);
    else n_pass++;
    for (int r = 1; r <= 6; r++) begin
      n_total++;
      if (dut.regs_q[r] !== 32'h0)
        $display("FAIL reset_reg%0d: got %h want %h", r, dut.regs_q[r], 32'h0);
      else n_pass++;
    end
    n_total++;
    if (dut.dmem_q[0] !== 32'h0) $display("FAIL reset_dmem0: got %h want %h", dut.dmem_q[0], 32'h0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (alu_result !== 32'd5) $display("FAIL reset_alu: got %h want %h", alu_result, 32'd5);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_arith();
    logic [31:0] exp_pc  [4];
    logic [31:0] exp_alu [4];
    logic [31:0] exp_reg [5];
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_alu = '{32'd5, 32'd3, 32'd8, 32'd2};
    exp_reg = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd2};
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (pc_out !== exp_pc[i]) $display("FAIL arith_pc%0d: got %h want %h", i, pc_out, exp_pc[i]);
      else n_pass++;
      n_total++;
      if (alu_result !== exp_alu[i])
        $display("FAIL arith_alu%0d: got %h want %h", i, alu_result, exp_alu[i]);
      else n_pass++;
      step();
    end
    for (int r = 1; r <= 4; r++) begin
      n_total++;
      if (dut.regs_q[r] !== exp_reg[r])
        $display("FAIL arith_reg%0d: got %h want %h", r, dut.regs_q[r], exp_reg[r]);
      else n_pass++;
    end
  endtask

  task automatic test_store_load();
    n_total++;
    if (pc_out !== 32'h10 || alu_result !== 32'h0)
      $display("FAIL sw_cycle: got pc=%h alu=%h want pc=10 alu=0", pc_out, alu_result);
    else n_pass++;
    step();
    n_total++;
    if (dut.dmem_q[0] !== 32'd8) $display("FAIL sw_dmem0: got %h want %h", dut.dmem_q[0], 32'd8);
    else n_pass++;
    n_total++;
    if (pc_out !== 32'h14 || alu_result !== 32'h0)
      $display("FAIL lw_cycle: got pc=%h alu=%h want pc=14 alu=0", pc_out, alu_result);
    else n_pass++;
    step();
    n_total++;
    if (dut.regs_q[5] !== 32'd8) $display("FAIL lw_reg5: got %h want %h", dut.regs_q[5], 32'd8);
    else n_pass++;
  endtask

  task automatic test_branch();
    n_total++;
    if (pc_out !== 32'h18 || alu_result !== 32'h0)
      $display("FAIL beq_cycle: got pc=%h alu=%h want pc=18 alu=0", pc_out, alu_result);
    else n_pass++;
    step();
    n_total++;
    if (pc_out !== 32'h20) $display("FAIL beq_target: got %h want %h", pc_out, 32'h20);
    else n_pass++;
    n_total++;
    if (dut.regs_q[6] !== 32'h0) $display("FAIL beq_skip_reg6: got %h want %h", dut.regs_q[6], 32'h0);
    else n_pass++;
  endtask

  task automatic test_jump();
    logic [31:0] exp_reg [7];
    exp_reg = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd2, 32'd8, 32'd0};
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (pc_out !== 32'h20 || alu_result !== 32'h0)
        $display("FAIL jump_loop%0d: got pc=%h alu=%h want pc=20 alu=0", i, pc_out, alu_result);
      else n_pass++;
      step();
    end
    for (int r = 0; r <= 6; r++) begin
      n_total++;
      if (dut.regs_q[r] !== exp_reg[r])
        $display("FAIL jump_reg%0d: got %h want %h", r, dut.regs_q[r], exp_reg[r]);
      else n_pass++;
    end
    n_total++;
    if (dut.dmem_q[0] !== 32'd8) $display("FAIL jump_dmem0: got %h want %h", dut.dmem_q[0], 32'd8);
    else n_pass++;
  endtask

  task automatic test_zero_reg_unknown();
    logic [31:0] exp_alu [4];
    exp_alu = '{32'd7, 32'd0, 32'd0, 32'd0};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (pc_out2 !== 32'(i * 4)) $display("FAIL alt_pc%0d: got %h want %h", i, pc_out2, 32'(i * 4));
      else n_pass++;
      n_total++;
      if (alu_result2 !== exp_alu[i])
        $display("FAIL alt_alu%0d: got %h want %h", i, alu_result2, exp_alu[i]);
      else n_pass++;
      step();
      #1;
    end
    for (int r = 0; r < 32; r++) begin
      n_total++;
      if (dut_alt.regs_q[r] !== 32'h0)
        $display("FAIL alt_reg%0d: got %h want %h", r, dut_alt.regs_q[r], 32'h0);
      else n_pass++;
    end
    n_total++;
    if (dut_alt.dmem_q[0] !== 32'h0)
      $display("FAIL alt_dmem0: got %h want %h", dut_alt.dmem_q[0], 32'h0);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    // test_reset ends one clock past release; restart cleanly for the program walk.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_arith();
    test_store_load();
    test_branch();
    test_jump();
    test_zero_reg_unknown();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
